// File: rtl/debug_pkg.sv
// Shared state encoding, command bytes and dump sizing for the pipeline debug controller.
// DBG_CYCLE_CNT_EN (defined at build time) selects the dump length that carries the cycle count.
package debug_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DUMP  = 3'd4
   } dbg_state_e;

   localparam logic [7:0]  CMD_RUN  = 8'h52;
   localparam logic [7:0]  CMD_STEP = 8'h53;
   localparam logic [7:0]  CMD_HALT = 8'h48;
   localparam logic [7:0]  CMD_DUMP = 8'h44;

   localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

   localparam int DUMP_BYTES_BASE = 32'sd170;
   localparam int DUMP_BYTES_CNT  = 32'sd174;

   // Bytes in one dump: 16-bit PC, register file, data memory, optional 32-bit count.
   function automatic int dump_bytes(input int reg_bits, input int mem_bits, input bit with_cnt);
      return 32'sd2 + reg_bits / 32'sd8 + mem_bits / 32'sd8 + (with_cnt ? 32'sd4 : 32'sd0);
   endfunction

endpackage

// File: rtl/dump_serializer.sv
// Parallel-load shift register that streams a snapshot LSB byte first over a valid/ready link.
// done_o pulses in the cycle the final byte is accepted.
module dump_serializer #(
   parameter int NBYTES = 170
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [NBYTES*8-1:0]   data_i,
   input  logic                  tx_ready_i,
   output logic                  tx_valid_o,
   output logic [7:0]            tx_data_o,
   output logic                  done_o
);

   localparam int IW = $clog2(NBYTES);

   logic [NBYTES*8-1:0] shift_q;
   logic [IW-1:0]       idx_q;
   logic                valid_q;
   logic                fire_s;
   logic                last_s;

   assign fire_s     = valid_q && tx_ready_i;
   assign last_s     = (idx_q == IW'(NBYTES - 1));
   assign done_o     = fire_s && last_s;
   assign tx_valid_o = valid_q;
   assign tx_data_o  = shift_q[7:0];

   // Load the snapshot, then drop one byte per accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         shift_q <= data_i;
         idx_q   <= '0;
         valid_q <= 1'b1;
      end else if (fire_s) begin
         shift_q <= {8'h00, shift_q[NBYTES*8-1:8]};
         if (last_s) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
         end else begin
            idx_q   <= idx_q + IW'(1);
         end
      end
   end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Run/step/halt controller and state-dump engine for the 5-stage pipeline.
// Define DBG_CYCLE_CNT_EN to count enabled pipeline cycles and append the count to the dump.
module pipeline_debug_ctrl
   import debug_pkg::*;
#(
   parameter int          PC_BITS      = 10,
   parameter int          REG_BITS     = 1024,
   parameter int          MEM_BITS     = 320,
   parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF,
   parameter int          DRAIN_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx_valid,
   input  logic [7:0]          rx_data,
   output logic                rx_ready,
   output logic                tx_valid,
   output logic [7:0]          tx_data,
   input  logic                tx_ready,
   input  logic [31:0]         instruction,
   input  logic [PC_BITS-1:0]  pc,
   input  logic [REG_BITS-1:0] registers,
   input  logic [MEM_BITS-1:0] memorias,
   output logic                pipe_en,
   output logic                halted
);

`ifdef DBG_CYCLE_CNT_EN
   localparam bit WITH_CNT = 1'b1;
`else
   localparam bit WITH_CNT = 1'b0;
`endif
   localparam int NBYTES  = dump_bytes(REG_BITS, MEM_BITS, WITH_CNT);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   dbg_state_e          state_q;
   logic [DRAIN_W-1:0]  drain_q;
   logic                halted_q;
   logic                cmd_acc_s;
   logic                halt_hit_s;
   logic                dump_load_s;
   logic                ser_done_s;
   logic [15:0]         pc_ext_s;
   logic [NBYTES*8-1:0] snap_s;

   assign rx_ready    = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign cmd_acc_s   = rx_valid && rx_ready;
   assign halt_hit_s  = (state_q == ST_RUN) && (instruction == HALT_WORD);
   assign dump_load_s = (state_q == ST_IDLE) && cmd_acc_s && (rx_data == CMD_DUMP);
   // The halt word freezes the pipe in the very cycle it shows up at IF/ID.
   assign pipe_en     = (state_q == ST_STEP) || (state_q == ST_DRAIN) ||
                        ((state_q == ST_RUN) && !halt_hit_s);
   assign halted      = halted_q;
   assign pc_ext_s    = 16'(pc);

`ifdef DBG_CYCLE_CNT_EN
   logic [31:0] cyc_q;

   // Count of enabled pipeline cycles since reset, wrapping at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q <= 32'd0;
      end else if (pipe_en) begin
         cyc_q <= cyc_q + 32'd1;
      end
   end

   assign snap_s = {cyc_q, memorias, registers, pc_ext_s};
`else
   assign snap_s = {memorias, registers, pc_ext_s};
`endif

   // Control FSM: command decode, halt-word detection and drain countdown.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         drain_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_acc_s) begin
                  if ((rx_data == CMD_RUN) && !halted_q) begin
                     state_q <= ST_RUN;
                  end else if ((rx_data == CMD_STEP) && !halted_q) begin
                     state_q <= ST_STEP;
                  end else if (rx_data == CMD_DUMP) begin
                     state_q <= ST_DUMP;
                  end
               end
            end
            ST_RUN: begin
               // The halt word takes priority over a host 'H' in the same cycle.
               if (halt_hit_s) begin
                  state_q  <= ST_DRAIN;
                  drain_q  <= DRAIN_W'(DRAIN_CYCLES);
                  halted_q <= 1'b1;
               end else if (cmd_acc_s && (rx_data == CMD_HALT)) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_STEP: begin
               state_q <= ST_IDLE;
            end
            ST_DRAIN: begin
               drain_q <= drain_q - DRAIN_W'(1);
               if (drain_q == DRAIN_W'(1)) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_DUMP: begin
               if (ser_done_s) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   dump_serializer #(
      .NBYTES(NBYTES)
   ) u_dump_serializer (
      .clk       (clk),
      .rst_n     (reset),
      .load_i    (dump_load_s),
      .data_i    (snap_s),
      .tx_ready_i(tx_ready),
      .tx_valid_o(tx_valid),
      .tx_data_o (tx_data),
      .done_o    (ser_done_s)
   );

endmodule

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Run/step/halt controller and state-dump engine for the 5-stage MIPS pipeline. Takes single-byte commands from a host byte link, gates the pipeline clock-enable to run, single-step or freeze it, and detects the program halt word. On request it snapshots the PC, the register file and the data memory, plus an optional cycle count, and streams them back byte-by-byte. It sits between the host link (UART wrapper) and the top-level pipeline.

## Interface
- `PC_BITS`, 10: width of the IF/ID PC.
- `REG_BITS`, 1024: flattened register file, 32×32.
- `MEM_BITS`, 320: flattened data memory, 10×32.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops the program.
- `DRAIN_CYCLES`, 4: enabled cycles after the halt word is detected, used to retire older instructions.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `rx_valid` in 1: command byte present.
- `rx_data` in 8: command byte.
- `rx_ready` out 1: command can be accepted.
- `tx_valid` out 1: dump byte present.
- `tx_data` out 8: dump byte.
- `tx_ready` in 1: host accepts the dump byte.
- `instruction` in 32: IF/ID instruction.
- `pc` in PC_BITS: IF/ID PC.
- `registers` in REG_BITS: register-file contents.
- `memorias` in MEM_BITS: data-memory contents.
- `pipe_en` out 1: pipeline clock-enable.
- `halted` out 1: sticky flag, program reached the halt word.

## Operation
- States are IDLE, RUN, STEP, DRAIN and DUMP.
- A command is accepted when `rx_valid && rx_ready`. `rx_ready` is 1 only in IDLE and RUN.
- Commands: 'R' (0x52), 'S' (0x53), 'H' (0x48), 'D' (0x44). Any other byte is consumed and ignored.
- **IDLE**
  - 'R' goes to RUN and 'S' goes to STEP, but only if `halted` is 0. Otherwise the command is ignored.
  - 'D' goes to DUMP.
  - 'H' is ignored.
- **RUN**
  - 'H' goes to IDLE.
  - When `instruction == HALT_WORD`, go to DRAIN, load the drain counter with DRAIN_CYCLES, and set `halted`.
  - 'R', 'S' and 'D' are ignored.
  - If 'H' and the halt word occur in the same cycle, the halt word wins and the block goes to DRAIN.
- **STEP**: lasts exactly one cycle, then returns to IDLE.
- **DRAIN**: the counter decrements every cycle; when it reaches 1, go to IDLE.
- **DUMP**
  - On entry, latch a snapshot shift register in this order: pc zero-extended to 16 bits, then `registers`, then `memorias`, then the cycle count (see Configuration).
  - Every field is sent little-endian: byte k = bits [8k+7:8k].
  - After the last byte is accepted, return to IDLE.
- `pipe_en` is combinational:
  - 1 in STEP and DRAIN.
  - 1 in RUN while `instruction != HALT_WORD`.
  - 0 otherwise.
- `halted` is cleared only by `reset`.

## Timing
- Reset values:
  - state = IDLE
  - `pipe_en` = 0, `halted` = 0
  - `tx_valid` = 0, `tx_data` = 0x00
  - `rx_ready` = 1
  - byte index and cycle counter = 0
- A command accepted in cycle N takes effect in cycle N+1: for 'R' or 'S', `pipe_en` is 1 in cycle N+1.
- STEP gives exactly one `pipe_en` pulse.
- Halt word present in cycle N:
  - `pipe_en` is 0 in cycle N.
  - `pipe_en` is 1 in cycles N+1 … N+DRAIN_CYCLES.
  - `pipe_en` is 0 from cycle N+DRAIN_CYCLES+1 on.
- Dump handshake:
  - `tx_valid` rises in the cycle after 'D' is accepted.
  - `tx_data` stays stable while `tx_valid && !tx_ready`.
  - One byte transfers per cycle when `tx_ready` is held high.
  - Total bytes: 170 without the cycle counter, 174 with it.
- An asynchronous reset asserted mid-dump or mid-drain aborts immediately and returns the block to its reset values.

## Configuration
- `DBG_CYCLE_CNT_EN` defined:
  - A 32-bit counter increments on every cycle with `pipe_en == 1` and wraps modulo 2^32.
  - The counter value is appended as 4 bytes at the end of the dump.
- `DBG_CYCLE_CNT_EN` undefined: no counter is built and the dump ends after the memory bytes.

## Structure
- Shared package `debug_pkg` holds:
  - the state enum;
  - command byte constants: CMD_RUN, CMD_STEP, CMD_HALT, CMD_DUMP;
  - `HALT_WORD` default;
  - dump byte-count constants, for both configurations.
- One sub-module: `dump_serializer`, a parallel-load shift register with the tx valid/ready handshake and a byte counter. It asserts `done` on the last accepted byte.

## Test plan
- Reset mid-dump: deassert reset after 5 cycles, send 'D' → exactly 170 bytes (174 with the macro). First two bytes are 0x00, 0x00. Bytes 2–5 equal `registers[31:0]` LSB first.
- 'S' sent three times with the program at pc=0 → `pipe_en` is high for exactly 3 non-adjacent cycles, and `pc` advances 0→1→2→3.
- 'R', then the halt word appears at cycle N → `pipe_en` is 0 at N, 1 for N+1..N+4, then 0. `halted` = 1, and a subsequent 'R' leaves `pipe_en` at 0.
- 'R' followed by 'H' five cycles later → `pipe_en` drops the cycle after 'H' is accepted. With the macro, the dump cycle count is 5.
- During a dump, hold `tx_ready` low for 10 cycles at byte 7 and send 'R' → `tx_data` holds steady, `rx_ready` stays 0, and the 'R' has no effect.
- 'H' and the halt word in the same cycle → the block enters DRAIN and produces exactly 4 enabled cycles.
